// File: rtl/icetap_pkg.sv
// Shared encodings for the icetap capture engine: FSM states and the
// per-signal mask field layout {edge_en, level_en, value}.
package icetap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_POST      = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   localparam int FLD_VALUE = 0;
   localparam int FLD_LEVEL = 1;
   localparam int FLD_EDGE  = 2;
   localparam int FLD_W     = 3;

endpackage

// File: rtl/icetap_capture_seq_if.sv
// Readout port of the capture engine: request strobes toward the sample
// memory, registered sample and valid strobe back.
interface icetap_capture_seq_if #(
   parameter int NR_SIGNALS = 16
);

   logic                  read_req_first;
   logic                  read_req_next;
   logic [NR_SIGNALS-1:0] read_data;
   logic                  read_valid;

   modport master (
      output read_req_first,
      output read_req_next,
      input  read_data,
      input  read_valid
   );

   modport slave (
      input  read_req_first,
      input  read_req_next,
      output read_data,
      output read_valid
   );

endinterface

// File: rtl/icetap_match.sv
// Combinational mask evaluator: hits when every enabled level/edge field
// holds for the current sample against the previous one.
module icetap_match
   import icetap_pkg::*;
#(
   parameter int NR_SIGNALS = 16
) (
   input  logic [NR_SIGNALS-1:0]       signals_in,
   input  logic [NR_SIGNALS-1:0]       prev,
   input  logic [NR_SIGNALS*FLD_W-1:0] mask,
   output logic                        hit
);

   always_comb begin
      hit = 1'b1;
      for (int i = 0; i < NR_SIGNALS; i++) begin
         if (mask[i*FLD_W + FLD_LEVEL] && (signals_in[i] != mask[i*FLD_W + FLD_VALUE]))
            hit = 1'b0;
         if (mask[i*FLD_W + FLD_EDGE] && (signals_in[i] == prev[i]))
            hit = 1'b0;
      end
   end

endmodule

// File: rtl/icetap_capture_seq.sv
// icetap capture engine: multi-stage trigger sequencer feeding a circular
// sample memory, with post-trigger count and sequential readout.
module icetap_capture_seq
   import icetap_pkg::*;
#(
   parameter int  NR_SIGNALS   = 16,
   parameter int  RECORD_DEPTH = 256,
   parameter int  NR_STAGES    = 4,
   localparam int AW           = $clog2(RECORD_DEPTH),
   localparam int SW           = $clog2(NR_STAGES) + 1
) (
   input  logic                                 src_clk,
   input  logic                                 src_reset,
   input  logic [NR_SIGNALS-1:0]                signals_in,
   input  logic [NR_SIGNALS*FLD_W-1:0]          store_mask_vec,
   input  logic                                 store_always,
   input  logic [NR_STAGES*NR_SIGNALS*FLD_W-1:0] trig_mask_vec,
   input  logic [SW-1:0]                        trig_stages,
   input  logic [AW:0]                          post_trig_count,
   input  logic                                 start,
   input  logic                                 abort,
   output logic [1:0]                           state,
   output logic [SW-1:0]                        stage,
   output logic                                 wrapped,
   output logic [AW-1:0]                        start_addr,
   output logic [AW-1:0]                        trigger_addr,
   output logic [AW-1:0]                        stop_addr,
   icetap_capture_seq_if.slave                  rd
);

   function automatic logic [SW-1:0] clamp_stages(input logic [SW-1:0] s);
      if (s > SW'(NR_STAGES)) return SW'(NR_STAGES);
      return s;
   endfunction

   function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
      if (c == '0) return (AW+1)'(1);
      if (c > (AW+1)'(RECORD_DEPTH)) return (AW+1)'(RECORD_DEPTH);
      return c;
   endfunction

   state_t                state_q, state_d;
   logic [NR_SIGNALS-1:0] prev;
   logic                  store_hit, cur_hit;
   logic [NR_STAGES-1:0]  trig_hit;
   logic                  arm, we, fire, adv, finish, rd_req;
   logic [SW-1:0]         stages_lat;
   logic [AW:0]           count_lat, remaining;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic                  rd_vld_p0;
   logic [NR_SIGNALS-1:0] mem [RECORD_DEPTH];

   icetap_match #(.NR_SIGNALS(NR_SIGNALS)) u_store_match (
      .signals_in (signals_in),
      .prev       (prev),
      .mask       (store_mask_vec),
      .hit        (store_hit)
   );

   for (genvar s = 0; s < NR_STAGES; s++) begin : g_trig
      icetap_match #(.NR_SIGNALS(NR_SIGNALS)) u_trig_match (
         .signals_in (signals_in),
         .prev       (prev),
         .mask       (trig_mask_vec[s*NR_SIGNALS*FLD_W +: NR_SIGNALS*FLD_W]),
         .hit        (trig_hit[s])
      );
   end

   always_comb begin
      cur_hit = 1'b0;
      for (int s = 0; s < NR_STAGES; s++)
         if (stage == SW'(s)) cur_hit = trig_hit[s];
   end

   always_ff @(posedge src_clk or posedge src_reset) begin
      if (src_reset) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      arm     = 1'b0;
      we      = 1'b0;
      fire    = 1'b0;
      adv     = 1'b0;
      finish  = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  arm     = 1'b1;
                  state_d = ST_WAIT_TRIG;
               end
            end
            ST_WAIT_TRIG: begin
               adv  = (stage < stages_lat) && cur_hit;
               fire = (stages_lat == '0) || (adv && ((stage + SW'(1)) == stages_lat));
               // The trigger sample is always stored, whatever the qualifier says.
               we   = fire || store_hit || store_always;
               if (fire) begin
                  if (count_lat == (AW+1)'(1)) begin
                     finish  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_POST;
                  end
               end
            end
            ST_POST: begin
               we = store_hit || store_always;
               if (we && (remaining == (AW+1)'(1))) begin
                  finish  = 1'b1;
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign state  = state_q;
   assign rd_req = (state_q == ST_DONE) && (rd.read_req_first || rd.read_req_next);

   always_ff @(posedge src_clk or posedge src_reset) begin
      if (src_reset) begin
         stage         <= '0;
         wrapped       <= 1'b0;
         start_addr    <= '0;
         trigger_addr  <= '0;
         stop_addr     <= '0;
         stages_lat    <= '0;
         count_lat     <= '0;
         remaining     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rd_vld_p0     <= 1'b0;
         rd.read_valid <= 1'b0;
         rd.read_data  <= '0;
      end else begin
         if (arm) begin
            stages_lat <= clamp_stages(trig_stages);
            count_lat  <= clamp_count(post_trig_count);
            wr_ptr     <= '0;
            stage      <= '0;
            wrapped    <= 1'b0;
         end
         if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == '1) wrapped <= 1'b1;
         end
         if (adv) stage <= stage + 1'b1;
         if (fire) begin
            trigger_addr <= wr_ptr;
            remaining    <= count_lat - 1'b1;
         end else if (we && (state_q == ST_POST)) begin
            remaining <= remaining - 1'b1;
         end
         // A write at the last address leaves the oldest sample at 0 either way.
         if (finish) begin
            stop_addr  <= wr_ptr;
            start_addr <= wrapped ? wr_ptr + 1'b1 : '0;
         end
         // Readout stage p0: pointer update; p1: registered memory read.
         if (rd_req) rd_ptr <= rd.read_req_first ? start_addr : rd_ptr + 1'b1;
         rd_vld_p0     <= rd_req;
         rd.read_valid <= rd_vld_p0;
         if (rd_vld_p0) rd.read_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge src_clk) begin
      prev <= signals_in;
      if (we) mem[wr_ptr] <= signals_in;
   end

endmodule

// File: doc/icetap_capture_seq.md
# icetap_capture_seq

Single-clock capture engine for the icetap logic analyzer. It succeeds the fixed-mode BRAM recorder with:
- a parametrised multi-stage trigger sequencer;
- a programmable post-trigger sample count;
- edge-qualified store and trigger masks;
- sequential readout with a valid strobe.

It sits in the `src_clk` domain, between the scan/config register block and the probed signals.

## Interface
Parameters:
- `NR_SIGNALS`, 16, width of probed signal vector
- `RECORD_DEPTH`, 256, sample memory depth; must be a power of 2, ≥ 4
- `NR_STAGES`, 4, trigger sequencer stages (≥ 1)
- Derived: `AW` = clog2(`RECORD_DEPTH`); `SW` = clog2(`NR_STAGES`)+1

Ports:
- `src_clk`  in  1  capture clock; the only clock
- `src_reset`  in  1  reset, asynchronous, active-high
- `signals_in`  in  `NR_SIGNALS`  probed signals
- `store_mask_vec`  in  `NR_SIGNALS`*3  store qualifier
- `store_always`  in  1  store every cycle; overrides `store_mask_vec`
- `trig_mask_vec`  in  `NR_STAGES`*`NR_SIGNALS`*3  per-stage trigger masks; stage s occupies slice s
- `trig_stages`  in  `SW`  number of stages to match; 0 = immediate trigger; values > `NR_STAGES` clamp to `NR_STAGES`
- `post_trig_count`  in  `AW`+1  stored samples from the trigger onward, trigger included; 0 is treated as 1; values > `RECORD_DEPTH` clamp
- `start`  in  1  pulse: arm capture
- `abort`  in  1  pulse: return to IDLE
- `state`  out  2  IDLE=0, WAIT_TRIG=1, POST=2, DONE=3
- `stage`  out  `SW`  current sequencer stage
- `wrapped`  out  1  memory has been overwritten at least once
- `start_addr`, `trigger_addr`, `stop_addr`  out  `AW`  oldest sample, trigger sample, last sample
- `read_req_first`, `read_req_next`  in  1  readout requests
- `read_data`  out  `NR_SIGNALS`  readout sample
- `read_valid`  out  1  `read_data` valid

## Operation
- Mask field per signal i is bits [3i+2:3i] = {edge_en, level_en, value}.
  - level_en: requires `signals_in`[i] == value.
  - edge_en: requires `signals_in`[i] != prev[i].
  - Both set: the signal must transition into value.
  - A mask hits when every enabled field holds. An all-zero mask always hits.
- prev is a register that loads `signals_in` every cycle.
- `start` in IDLE or DONE:
  - Latches `trig_stages` and `post_trig_count` (with clamping).
  - Clears `wr_ptr`, `stage` and `wrapped`.
  - Enters WAIT_TRIG.
  - `start` is ignored in WAIT_TRIG and POST.
- WAIT_TRIG:
  - Store when store hit is true or `store_always` is set: write `signals_in` to mem[`wr_ptr`], then `wr_ptr`++.
  - When `wr_ptr` wraps from `RECORD_DEPTH`-1 to 0, set `wrapped`.
  - If `stage` < latched stages and trig_mask[`stage`] hits: `stage`++. At most one advance per cycle.
  - Trigger fires in the cycle `stage` would reach the latched stage count (immediately when the count is 0).
- Trigger cycle:
  - The sample is stored regardless of the store qualifier.
  - `trigger_addr` = `wr_ptr`.
  - remaining = count-1.
  - If remaining == 0: go to DONE. Otherwise go to POST.
- POST: each store decrements remaining. When it reaches 0, go to DONE.
- Entering DONE:
  - `stop_addr` = address just written.
  - `start_addr` = `wrapped` ? `stop_addr`+1 (mod depth) : 0.
- `abort` in any state: go to IDLE; the address outputs hold their values. `abort` and `start` in the same cycle: `abort` wins.
- Readout, honoured only in DONE:
  - `read_req_first` loads rd_ptr = `start_addr`.
  - `read_req_next` increments rd_ptr (wraps).
  - If both are asserted, first wins.
  - Requests outside DONE are ignored and `read_valid` stays 0.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE; `stage`=0; `wrapped`=0.
  - All address outputs = 0.
  - `read_data`=0; `read_valid`=0.
  - Memory contents are not reset.
- Hits are evaluated combinationally from `signals_in`/prev. The write happens on the same edge.
- `start` at edge t: state=WAIT_TRIG after t. The first sample that can be stored is the one presented at t+1.
- Trigger at edge t: state=POST (or DONE) visible after t; `trigger_addr` is valid from t+1.
- Readout latency: a request at edge t gives `read_data`/`read_valid` after edge t+1. `read_valid` is a one-cycle pulse per request.
- `post_trig_count`=`RECORD_DEPTH`: `start_addr` == `trigger_addr` once wrapped.

## Structure
- The package `icetap_pkg` holds:
  - the state encodings;
  - mask field offsets (VALUE=0, LEVEL=1, EDGE=2) and field width 3.
- Sub-module `icetap_match`: combinational mask evaluator (`signals_in`, prev, mask → hit). It is instantiated `NR_STAGES`+1 times.
- Memory is inferred as a simple dual-port BRAM with a registered read.

## Test plan
- Immediate trigger: `trig_stages`=0, `post_trig_count`=4, `store_always`=1, counter on `signals_in`, `start` → DONE 4 cycles after arm; `trigger_addr`=0, `stop_addr`=3, `start_addr`=0.
- Two-stage sequence: stage0 = level sig0=1, stage1 = rising edge sig1. A sig1 rise before sig0 is ignored; a sig1 rise after sig0 triggers; `stage` reads 1 in between.
- Wrap: depth 256, `store_always`, trigger at sample 300, `post_trig_count`=16 → `wrapped`=1, `stop_addr`=59, `start_addr`=60, `trigger_addr`=44.
- Store qualifier: `store_mask` on sig2 level=1, sig2 high every 4th cycle → only those samples are written; the trigger sample is stored even with sig2=0.
- Readout: after DONE, `read_req_first` then 3×`read_req_next` → 4 `read_valid` pulses, each one cycle after its request, returning memory from `start_addr` onward.
- `abort`+`start` in the same cycle during POST → IDLE, addresses unchanged. A `src_reset` pulse mid-capture → all outputs return to reset values asynchronously.
